// File: rtl/carry_cfg_pkg.sv
// carry_cfg_pkg: shared constants and types for the carry-chain config controller.
//   SLICE_BITS      : config bits per slice (fixed at 5)
//   *_POS / CYSEL_* : field offsets inside one slice
//   CYSEL_MAX       : highest legal CYMUX0_select code
//   state_e         : controller FSM states
//   ERR_*           : err_code values
package carry_cfg_pkg;

  localparam int SLICE_BITS = 5;
  localparam int BYPASS_POS = 0;
  localparam int SELMUX_POS = 1;
  localparam int CYSEL_LSB  = 2;
  localparam int CYSEL_MSB  = 4;
  localparam int CYSEL_W    = CYSEL_MSB - CYSEL_LSB + 1;

  localparam logic [CYSEL_W-1:0] CYSEL_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_SEL    = 2'b01;
  localparam logic [1:0] ERR_PARITY = 2'b10;

  function automatic logic cysel_legal(input logic [CYSEL_W-1:0] sel);
    return sel <= CYSEL_MAX;
  endfunction

endpackage

// File: rtl/carry_chain_cfg_ctrl_if.sv
// carry_chain_cfg_ctrl_if: serial config stream handshake.
//   cfg_valid : source has a bit this cycle
//   cfg_bit   : serial data
//   cfg_ready : controller accepts a bit this cycle
// master = bit source, slave = controller.
interface carry_chain_cfg_ctrl_if;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;

  modport master (output cfg_valid, output cfg_bit, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_bit, output cfg_ready);
endinterface

// File: rtl/carry_cfg_field_check.sv
// carry_cfg_field_check: combinational legality check of a staged frame.
//   shadow  : NUM_SLICES*SLICE_BITS data bits, slice k at [k*5 +: 5]
//   illegal : some slice carries a CYMUX0_select code above CYSEL_MAX
module carry_cfg_field_check
  import carry_cfg_pkg::*;
#(
  parameter int NUM_SLICES = 8
) (
  input  logic [NUM_SLICES*SLICE_BITS-1:0] shadow,
  output logic                             illegal
);

  logic [NUM_SLICES-1:0] bad;
  // bypass / carryOut_sel_mux take any value; they are only folded here so
  // the whole shadow vector is consumed.
  logic [NUM_SLICES-1:0] unused_flags;

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    assign bad[k] = !cysel_legal(shadow[k*SLICE_BITS+CYSEL_LSB +: CYSEL_W]);
    assign unused_flags[k] = shadow[k*SLICE_BITS+BYPASS_POS] ^
                             shadow[k*SLICE_BITS+SELMUX_POS];
  end

  assign illegal = |bad;

endmodule

// File: rtl/carry_chain_cfg_ctrl.sv
// carry_chain_cfg_ctrl: serial configuration controller for one column of
// fast-carry-chain slices. Bits are staged in a shadow register, checked,
// then committed to cfg_bus in a single edge.
//   clk, reset : clock, synchronous active-high reset
//   start      : opens a frame (IDLE only)
//   abort      : drops the frame in SHIFT/CHECK
//   cfg        : serial stream handshake (slave side)
//   cfg_bus    : active configuration, slice k at [k*5 +: 5]
//   busy       : FSM not in IDLE
//   cfg_done   : pulse, new cfg_bus visible
//   cfg_err    : pulse, frame rejected; err_code holds reason until next start
// Optional: define CARRY_CFG_PARITY_EN for a trailing even-parity bit.
module carry_chain_cfg_ctrl
  import carry_cfg_pkg::*;
#(
  parameter int NUM_SLICES = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  carry_chain_cfg_ctrl_if.slave            cfg,
  output logic [NUM_SLICES*SLICE_BITS-1:0] cfg_bus,
  output logic                             busy,
  output logic                             cfg_done,
  output logic                             cfg_err,
  output logic [1:0]                       err_code
);

  localparam int DATA_LEN = NUM_SLICES * SLICE_BITS;
`ifdef CARRY_CFG_PARITY_EN
  localparam int FRAME_LEN = DATA_LEN + 1;
`else
  localparam int FRAME_LEN = DATA_LEN;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN);

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_LEN-1:0] shadow;
  logic                 ready_q;
  logic                 illegal;
  logic                 parity_bad;

  carry_cfg_field_check #(.NUM_SLICES(NUM_SLICES)) u_check (
    .shadow  (shadow[DATA_LEN-1:0]),
    .illegal (illegal)
  );

`ifdef CARRY_CFG_PARITY_EN
  assign parity_bad = ^shadow;
`else
  assign parity_bad = 1'b0;
`endif

  assign cfg.cfg_ready = ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shadow   <= '0;
      ready_q  <= 1'b0;
      busy     <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      err_code <= ERR_NONE;
      cfg_bus  <= '0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt    <= '0;
          shadow <= '0;
          if (start) begin
            state    <= ST_SHIFT;
            ready_q  <= 1'b1;
            busy     <= 1'b1;
            err_code <= ERR_NONE;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
            busy    <= 1'b0;
          end else if (cfg.cfg_valid && ready_q) begin
            // Right shift: after FRAME_LEN bits the first bit sits at bit0.
            shadow <= {cfg.cfg_bit, shadow[FRAME_LEN-1:1]};
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state   <= ST_CHECK;
              ready_q <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (illegal || parity_bad) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            cfg_err  <= 1'b1;
            err_code <= illegal ? ERR_SEL : ERR_PARITY;
          end else begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // abort is deliberately not looked at: the commit always lands.
          cfg_bus  <= shadow[DATA_LEN-1:0];
          cfg_done <= 1'b1;
          state    <= ST_IDLE;
          busy     <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
